// File: rtl/npu_acc_drain_if.sv
// Drain-side bus of the NPU outer-product stage: drain request/config in,
// PE clear and status out, plus the valid/ready result stream.
interface npu_acc_drain_if #(
    parameter int NUM_PE      = 4,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int IDX_WIDTH   = $clog2(NUM_PE)
);
    logic                        start;
    logic [NUM_PE*ACC_WIDTH-1:0] acc_in;
    logic [SCALE_WIDTH-1:0]      scale;
    logic [SHIFT_WIDTH-1:0]      shift;
    logic [OUT_WIDTH-1:0]        zero_point;
    logic                        pe_clear;
    logic                        busy;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_WIDTH-1:0]        out_data;
    logic [IDX_WIDTH-1:0]        out_index;
    logic                        out_last;
    logic                        done;

    modport master (
        output start, acc_in, scale, shift, zero_point, out_ready,
        input  pe_clear, busy, out_valid, out_data, out_index, out_last, done
    );

    modport slave (
        input  start, acc_in, scale, shift, zero_point, out_ready,
        output pe_clear, busy, out_valid, out_data, out_index, out_last, done
    );
endinterface

// File: rtl/npu_acc_drain.sv
// Snapshots a PE row's accumulators, pulses their clear, and streams the
// requantized (scale, rounding shift, zero point, saturate) results out.
module npu_acc_drain #(
    parameter int NUM_PE      = 4,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int IDX_WIDTH   = $clog2(NUM_PE)
) (
    input  logic            clk,
    input  logic            rst,
    npu_acc_drain_if.slave  io
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;
    localparam int QW = PW + 1;
    localparam int CW = IDX_WIDTH + 1;

    localparam logic signed [QW-1:0] QMAX = {{(QW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0] QMIN = {{(QW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [1:0]                        state_q, state_d;
    logic [NUM_PE-1:0][ACC_WIDTH-1:0]  snap_q;
    logic [SCALE_WIDTH-1:0]            scale_q;
    logic [SHIFT_WIDTH-1:0]            shift_q;
    logic [OUT_WIDTH-1:0]              zp_q;
    logic [CW-1:0]                     cnt_q;
    logic                              pe_clear_q, done_q;
    logic                              out_valid_q, out_last_q;
    logic [OUT_WIDTH-1:0]              out_data_q;
    logic [IDX_WIDTH-1:0]              out_index_q;

    logic                    take, load, fin;
    logic signed [ACC_WIDTH-1:0] acc_sel;
    logic signed [PW-1:0]    acc_ext, scl_ext, prod, rnd, r;
    logic signed [QW-1:0]    q;
    logic [OUT_WIDTH-1:0]    res;

    assign take = (state_q == IDLE) && io.start;
    assign load = (state_q == STREAM) && (!out_valid_q || io.out_ready)
                  && (cnt_q < CW'(NUM_PE));
    // Counter already past the last PE, so this handshake closes the stream.
    assign fin  = (state_q == STREAM) && out_valid_q && io.out_ready
                  && (cnt_q == CW'(NUM_PE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.start) state_d = STREAM;
            STREAM:  if (fin) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign acc_sel = snap_q[cnt_q[IDX_WIDTH-1:0]];

    always_comb begin
        acc_ext = {{(PW-ACC_WIDTH){acc_sel[ACC_WIDTH-1]}}, acc_sel};
        scl_ext = {{(PW-SCALE_WIDTH){1'b0}}, scale_q};
        prod    = acc_ext * scl_ext;
        rnd     = prod;
        r       = prod;
        if (shift_q != '0) begin
            rnd = prod + (PW'(1) << (shift_q - SHIFT_WIDTH'(1)));
            r   = rnd >>> shift_q;
        end
        // One guard bit above the product so the zero-point add cannot wrap.
        q = {r[PW-1], r} + {{(QW-OUT_WIDTH){zp_q[OUT_WIDTH-1]}}, zp_q};
        if (q > QMAX)      res = QMAX[OUT_WIDTH-1:0];
        else if (q < QMIN) res = QMIN[OUT_WIDTH-1:0];
        else               res = q[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            scale_q     <= '0;
            shift_q     <= '0;
            zp_q        <= '0;
            cnt_q       <= '0;
            pe_clear_q  <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else begin
            state_q    <= state_d;
            pe_clear_q <= take;
            done_q     <= fin;
            if (take) begin
                snap_q  <= io.acc_in;
                scale_q <= io.scale;
                shift_q <= io.shift;
                zp_q    <= io.zero_point;
                cnt_q   <= '0;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res;
                out_index_q <= cnt_q[IDX_WIDTH-1:0];
                out_last_q  <= (cnt_q == CW'(NUM_PE - 1));
                cnt_q       <= cnt_q + CW'(1);
            end else if (fin) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign io.pe_clear  = pe_clear_q;
    assign io.busy      = (state_q != IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_index = out_index_q;
    assign io.out_last  = out_last_q;
    assign io.done      = done_q;
endmodule

// File: tb/tb_npu_acc_drain.sv
// Scoreboard bench for npu_acc_drain: directed vectors queue their expected
// elements, a negedge monitor pops and compares on every handshake.
module tb_npu_acc_drain;
    localparam int NPE = 4, AW = 24, OW = 8, SW = 16, HW = 5, IW = 2;

    typedef struct { int data; int idx; bit last; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npu_acc_drain_if #(.NUM_PE(NPE), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
                       .SCALE_WIDTH(SW), .SHIFT_WIDTH(HW), .IDX_WIDTH(IW)) bus ();

    npu_acc_drain #(.NUM_PE(NPE), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
                    .SCALE_WIDTH(SW), .SHIFT_WIDTH(HW), .IDX_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0;
    int   n_done = 0, n_clr = 0, hs_cnt = 0, exp_done = 0;
    int   acc_v[NPE], exp_v[NPE];
    bit   rand_rdy = 1'b0, rdy_force = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Ready source: either forced level or ~40% random.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = rand_rdy ? ($urandom_range(0, 99) < 40) : rdy_force;
        end
    end

    // Monitor: handshake scoreboard, hold-stability under stall, pulse counts.
    bit   stall_q = 1'b0;
    int   pd, pi, pl;
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (bus.pe_clear) n_clr++;
            if (bus.done) n_done++;
            if (stall_q) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_data", int'($signed(bus.out_data)), pd);
                chk("hold_index", int'(bus.out_index), pi);
                chk("hold_last", int'(bus.out_last), pl);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", int'($signed(bus.out_data)), e.data);
                    chk("out_index", int'(bus.out_index), e.idx);
                    chk("out_last", int'(bus.out_last), int'(e.last));
                end
                hs_cnt++;
            end
            stall_q = bus.out_valid && !bus.out_ready;
            pd = int'($signed(bus.out_data));
            pi = int'(bus.out_index);
            pl = int'(bus.out_last);
        end
    end

    task automatic start_txn(input int sc, input int sh, input int zp, input bit push);
        @(posedge clk); #1;
        for (int k = 0; k < NPE; k++) bus.acc_in[k*AW +: AW] = acc_v[k][AW-1:0];
        bus.scale      = sc[SW-1:0];
        bus.shift      = sh[HW-1:0];
        bus.zero_point = zp[OW-1:0];
        bus.start      = 1'b1;
        if (push)
            for (int k = 0; k < NPE; k++) sb.push_back('{exp_v[k], k, k == NPE-1});
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (n_done >= target) break;
        end
        chk("done_count", n_done, target);
    endtask

    task automatic run_txn(input int sc, input int sh, input int zp);
        exp_done++;
        start_txn(sc, sh, zp, 1'b1);
        wait_done(exp_done);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_data"}, int'(bus.out_data), 0);
        chk({tag, "_index"}, int'(bus.out_index), 0);
        chk({tag, "_last"}, int'(bus.out_last), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_clear"}, int'(bus.pe_clear), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Per-cycle expectations after start at edge T: {pe_clear, out_valid, done, busy}.
    int tl_clr[7] = '{1, 0, 0, 0, 0, 0, 0};
    int tl_vld[7] = '{0, 1, 1, 1, 1, 0, 0};
    int tl_dne[7] = '{0, 0, 0, 0, 0, 1, 0};
    int tl_bsy[7] = '{1, 1, 1, 1, 1, 1, 0};

    initial begin
        int clr_b, d_b, base;
        bus.start = 1'b0; bus.acc_in = '0; bus.scale = '0;
        bus.shift = '0; bus.zero_point = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Unity path with cycle-exact timeline
        acc_v = '{5, -3, 100, -100}; exp_v = '{5, -3, 100, -100};
        exp_done++;
        start_txn(1, 0, 0, 1'b1);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("tl_clear_c%0d", c+1), int'(bus.pe_clear), tl_clr[c]);
            chk($sformatf("tl_valid_c%0d", c+1), int'(bus.out_valid), tl_vld[c]);
            chk($sformatf("tl_done_c%0d", c+1), int'(bus.done), tl_dne[c]);
            chk($sformatf("tl_busy_c%0d", c+1), int'(bus.busy), tl_bsy[c]);
        end
        wait_done(exp_done);

        // Saturation
        acc_v = '{1000, -1000, 127, -128}; exp_v = '{127, -128, 127, -128};
        run_txn(1, 0, 0);
        acc_v = '{100, 100, 100, 100}; exp_v = '{117, 117, 117, 117};
        run_txn(300, 8, 0);
        // Rounding half toward +inf
        acc_v = '{6, 5, -6, -5}; exp_v = '{2, 1, -1, -1};
        run_txn(1, 2, 0);
        // Zero point
        acc_v = '{0, 0, 0, 0}; exp_v = '{10, 10, 10, 10};
        run_txn(1, 0, 10);
        acc_v = '{-120, -120, -120, -120}; exp_v = '{-128, -128, -128, -128};
        run_txn(1, 0, -20);
        // Extreme accumulators, max scale, max shift
        acc_v = '{-8388608, 8388607, 0, -1}; exp_v = '{-128, 127, 0, 0};
        run_txn(65535, 31, 0);
        // scale 0 passes only the (saturated) zero point
        acc_v = '{8388607, -8388608, 42, -42}; exp_v = '{127, 127, 127, 127};
        run_txn(0, 0, 127);
        acc_v = '{-1, -1, 0, 1}; exp_v = '{-128, -128, -128, -127};
        run_txn(1, 0, -128);

        // Start while busy is ignored
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        clr_b = n_clr;
        acc_v = '{11, 22, 33, 44}; exp_v = '{11, 22, 33, 44};
        exp_done++;
        start_txn(1, 0, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NPE; k++) bus.acc_in[k*AW +: AW] = 24'sd99;
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        chk("busy_start_clear_once", n_clr, clr_b + 1);
        rdy_force = 1'b1;
        wait_done(exp_done);

        // Random backpressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 50; t++) begin
            for (int k = 0; k < NPE; k++) begin
                acc_v[k] = ((t * 7 + k * 13) % 200) - 100;
                exp_v[k] = acc_v[k];
            end
            run_txn(1, 0, 0);
        end
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);

        // Reset mid-stream after index 1 is accepted
        base = hs_cnt;
        acc_v = '{7, 8, 9, 10}; exp_v = '{7, 8, 9, 10};
        start_txn(1, 0, 0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (hs_cnt >= base + 2) break;
        end
        chk("abort_hs_reached", int'(hs_cnt >= base + 2), 1);
        #1 rst = 1'b1;
        sb.delete();
        d_b = n_done;
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("abort");
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        chk("abort_no_done", n_done, d_b);
        acc_v = '{-1, 2, -3, 4}; exp_v = '{-1, 2, -3, 4};
        run_txn(1, 0, 0);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("total_done", n_done, exp_done);
        chk("total_clear", n_clr, exp_done + 1);
        @(negedge clk);
        chk("final_busy", int'(bus.busy), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
